// File: rtl/sram_access_sequencer_pkg.sv
// Shared types and constants for the SRAM access sequencer: bus widths, access
// widths, FSM state encoding, the queued request entry and its validity check.
package sram_access_sequencer_pkg;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [ADDR_BUS-1:0] ZERO_ADDR = 32'h0000_0000;
    localparam logic [DATA_BUS-1:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [3:0] WIDTH_BYTE = 4'd1;
    localparam logic [3:0] WIDTH_HALF = 4'd2;
    localparam logic [3:0] WIDTH_WORD = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic                we;
        logic [ADDR_BUS-1:0] addr;
        logic [3:0]          width;
        logic [DATA_BUS-1:0] data;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    // A request is legal only for widths 1/2/4 with the address aligned to that width.
    function automatic logic req_is_legal(input logic [ADDR_BUS-1:0] addr,
                                          input logic [3:0]          width);
        logic ok;
        case (width)
            WIDTH_BYTE: ok = TRUE;
            WIDTH_HALF: ok = (addr[0] == 1'b0);
            WIDTH_WORD: ok = (addr[1:0] == 2'b00);
            default:    ok = FALSE;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sram_access_sequencer_if.sv
// Request/response handshake bundle between a requester (master) and the
// SRAM access sequencer (slave).
interface sram_access_sequencer_if;
    import sram_access_sequencer_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_BUS-1:0] req_addr;
    logic [3:0]          req_width;
    logic [DATA_BUS-1:0] req_data;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_BUS-1:0] rsp_data;
    logic                rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_width, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_width, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/sram_access_sequencer_sync_fifo.sv
// Synchronous FIFO with show-ahead head data; pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; push and pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage has no reset: an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

// File: rtl/sram_access_sequencer.sv
// Queues load/store requests and replays each one to the mem unit as a fixed
// ACCESS_CYCLES-long chip-enable window, returning one in-order response each.
module sram_access_sequencer
    import sram_access_sequencer_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_access_sequencer_if.slave bus,
    output logic                 busy,
    output logic                 sram_ce_o,
    output logic                 sram_we_o,
    output logic [ADDR_BUS-1:0]  sram_addr_o,
    output logic [3:0]           sram_width_o,
    output logic [DATA_BUS-1:0]  sram_data_o,
    input  logic [DATA_BUS-1:0]  sram_data_i
);
    localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    seq_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ce_q;
    logic                we_q;
    logic [ADDR_BUS-1:0] addr_q;
    logic [3:0]          width_q;
    logic [DATA_BUS-1:0] wdata_q;
    logic                rsp_valid_q;
    logic [DATA_BUS-1:0] rsp_data_q;
    logic                rsp_err_q;

    req_entry_t          push_entry_s;
    req_entry_t          head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                req_ready_s;
    logic                push_s;
    logic                pop_s;

    // Ready is forced low during reset so nothing is accepted on the reset edge.
    assign req_ready_s  = !fifo_full_s && !rst;
    assign push_s       = bus.req_valid && req_ready_s;
    assign pop_s        = (state_q == ST_IDLE) && !fifo_empty_s;
    assign push_entry_s = '{we: bus.req_we, addr: bus.req_addr, width: bus.req_width, data: bus.req_data};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i (push_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Sequencer FSM; every SRAM-side and response-side output is a register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ce_q        <= FALSE;
            we_q        <= FALSE;
            addr_q      <= ZERO_ADDR;
            width_q     <= 4'd0;
            wdata_q     <= ZERO_WORD;
            rsp_valid_q <= FALSE;
            rsp_data_q  <= ZERO_WORD;
            rsp_err_q   <= FALSE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        if (req_is_legal(head_s.addr, head_s.width)) begin
                            ce_q    <= TRUE;
                            we_q    <= head_s.we;
                            addr_q  <= head_s.addr;
                            width_q <= head_s.width;
                            wdata_q <= head_s.data;
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_ACCESS;
                        end else begin
                            rsp_valid_q <= TRUE;
                            rsp_err_q   <= TRUE;
                            rsp_data_q  <= ZERO_WORD;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        rsp_data_q  <= we_q ? ZERO_WORD : sram_data_i;
                        rsp_valid_q <= TRUE;
                        rsp_err_q   <= FALSE;
                        ce_q        <= FALSE;
                        we_q        <= FALSE;
                        addr_q      <= ZERO_ADDR;
                        width_q     <= 4'd0;
                        wdata_q     <= ZERO_WORD;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= FALSE;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    ce_q        <= FALSE;
                    rsp_valid_q <= FALSE;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = !fifo_empty_s || (state_q != ST_IDLE);
    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign sram_ce_o     = ce_q;
    assign sram_we_o     = we_q;
    assign sram_addr_o   = addr_q;
    assign sram_width_o  = width_q;
    assign sram_data_o   = wdata_q;
endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for the SRAM access sequencer with a byte-addressed,
// little-endian memory model standing in for the mem unit.
module tb_sram_access_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic        sram_ce;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [3:0]  sram_width;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [7:0]  mem [64] = '{default: 8'h00};

    int vectors    = 0;
    int miscompares = 0;

    sram_access_sequencer_if bus ();

    sram_access_sequencer #(.DEPTH(4), .ACCESS_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .sram_ce_o    (sram_ce),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_width_o (sram_width),
        .sram_data_o  (sram_wdata),
        .sram_data_i  (sram_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: zero-extended read of `width` bytes, write on every ce&&we cycle.
    always_comb begin
        sram_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(sram_width)) sram_rdata[8*i +: 8] = mem[6'(sram_addr[5:0] + 6'(i))];
        end
    end

    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(sram_width)) mem[6'(sram_addr[5:0] + 6'(i))] <= sram_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request with rsp_ready=1 and check latency, ce/we window and response.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] width, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int exp_ce);
        int n = 0;
        int lat = 1;
        int ce_n = 0;
        int we_n = 0;
        bus.rsp_ready = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_width = width;
        bus.req_data  = data;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (!bus.rsp_valid && lat < 20) begin
            if (sram_ce) ce_n++;
            if (sram_we) we_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, bus.rsp_data, exp_data);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_ce_cycles"}, 32'(ce_n), 32'(exp_ce));
        check({tag, "_we_cycles"}, 32'(we_n), we ? 32'(exp_ce) : 32'd0);
        @(negedge clk);
        check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    // Offer one request for a bounded number of cycles; report whether it was taken.
    task automatic push_only(input logic we, input logic [31:0] addr, input logic [3:0] width,
                             input logic [31:0] data, output bit taken);
        int n = 0;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_width = width;
        bus.req_data  = data;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 4) begin
            @(negedge clk);
            n++;
        end
        taken = bus.req_ready;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] b2b_addr [4]  = '{32'd8, 32'd14, 32'd16, 32'd12};
        logic [3:0]  b2b_width [4] = '{4'd4, 4'd2, 4'd1, 4'd4};
        logic [31:0] b2b_exp [4]   = '{32'hdeadbeef, 32'h0000beef, 32'h000000de, 32'hbeef0000};
        logic [31:0] bp_addr [5]   = '{32'd8, 32'd14, 32'd16, 32'd16, 32'd3};
        logic [3:0]  bp_width [5]  = '{4'd4, 4'd2, 4'd1, 4'd2, 4'd2};
        logic [31:0] bp_exp [5]    = '{32'hdeadbeef, 32'h0000beef, 32'h000000de, 32'h000000de, 32'h0};
        logic        bp_err [5]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          seen_cyc [$];
        logic [31:0] seen_dat [$];
        bit          taken;
        int          accepted;
        int          n;
        int          stray;
        bit          rdy_seen;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_width = 4'd0;
        bus.req_data  = 32'h0;
        bus.rsp_ready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ce", 32'(sram_ce), 32'd0);
        check("rst_addr", sram_addr, 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Stores followed by loads of each width, then two rejected requests
        do_req("st_word", 1'b1, 32'd8, 4'd4, 32'hdeadbeef, 32'h0, 1'b0, 4, 2);
        do_req("ld_word", 1'b0, 32'd8, 4'd4, 32'h0, 32'hdeadbeef, 1'b0, 4, 2);
        do_req("st_half", 1'b1, 32'd14, 4'd2, 32'h0000beef, 32'h0, 1'b0, 4, 2);
        do_req("ld_half", 1'b0, 32'd14, 4'd2, 32'h0, 32'h0000beef, 1'b0, 4, 2);
        do_req("st_byte", 1'b1, 32'd16, 4'd1, 32'h000000de, 32'h0, 1'b0, 4, 2);
        do_req("ld_byte", 1'b0, 32'd16, 4'd1, 32'h0, 32'h000000de, 1'b0, 4, 2);
        do_req("ld_misaligned", 1'b0, 32'd13, 4'd2, 32'h0, 32'h0, 1'b1, 2, 0);
        do_req("ld_width3", 1'b0, 32'd4, 4'd3, 32'h0, 32'h0, 1'b1, 2, 0);

        // Back-to-back loads: responses at cycles 4, 8, 12, 16 after the first push
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (bus.rsp_valid) begin
                seen_cyc.push_back(c);
                seen_dat.push_back(bus.rsp_data);
            end
            bus.req_valid = (c < 4);
            bus.req_we    = 1'b0;
            bus.req_addr  = b2b_addr[c % 4];
            bus.req_width = b2b_width[c % 4];
            @(negedge clk);
        end
        check("b2b_count", 32'(seen_cyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("b2b_cycle", (i < seen_cyc.size()) ? 32'(seen_cyc[i]) : 32'hffffffff, 32'(4 + 4 * i));
            check("b2b_data", (i < seen_dat.size()) ? seen_dat[i] : 32'hffffffff, b2b_exp[i]);
        end

        // Backpressure: 7 offers with rsp_ready low, only DEPTH+1 fit
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 7; i++) begin
            push_only(1'b0, bp_addr[i % 5], bp_width[i % 5], 32'h0, taken);
            if (taken) accepted++;
        end
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        rdy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!bus.rsp_valid && n < 20) begin
                if (bus.req_ready) rdy_seen = 1'b1;
                @(negedge clk);
                n++;
            end
            if (i == 0) check("bp_ready_before_pop", 32'(bus.req_ready), 32'd0);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_data", bus.rsp_data, bp_exp[i]);
            check("bp_rsp_err", 32'(bus.rsp_err), 32'(bp_err[i]));
            @(negedge clk);
        end
        check("bp_ready_reasserted", 32'(rdy_seen), 32'd1);

        // Reset in the first ACCESS cycle of a load with three more queued
        bus.rsp_ready = 1'b0;
        accepted = 0;
        push_only(1'b1, 32'd20, 4'd4, 32'h11223344, taken);
        if (taken) accepted++;
        for (int i = 0; i < 4; i++) begin
            push_only(1'b0, 32'd8, 4'd4, 32'h0, taken);
            if (taken) accepted++;
        end
        check("rr_accepted", 32'(accepted), 32'd5);
        check("rr_store_rsp", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!sram_ce && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rr_in_access", 32'(sram_ce), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rr_ce", 32'(sram_ce), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rr_req_ready_in_rst", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rr_req_ready_after", 32'(bus.req_ready), 32'd1);
        check("rr_busy_after", 32'(busy), 32'd0);
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.rsp_valid || sram_ce) stray++;
            @(negedge clk);
        end
        check("rr_no_activity", 32'(stray), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
